// File: rtl/ctrl_decode_pipe_if.sv
// Shared opcode, command and control-bundle types, plus the ID-to-EXE control bus
// that connects the ID stage to the ctrl_decode_pipe block.
package ctrl_decode_pkg;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_NOR  = 6'd5,
    OP_XOR  = 6'd6,
    OP_SLA  = 6'd7,
    OP_SLL  = 6'd8,
    OP_SRA  = 6'd9,
    OP_SRL  = 6'd10,
    OP_MUL  = 6'd11,
    OP_ADDI = 6'd32,
    OP_SUBI = 6'd33,
    OP_LD   = 6'd36,
    OP_ST   = 6'd37,
    OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41,
    OP_JMP  = 6'd42
  } opcode_t;

  typedef enum logic [3:0] {
    EXE_NO_OPERATION = 4'd0,
    EXE_ADD          = 4'd1,
    EXE_SUB          = 4'd2,
    EXE_AND          = 4'd3,
    EXE_OR           = 4'd4,
    EXE_NOR          = 4'd5,
    EXE_XOR          = 4'd6,
    EXE_SLA          = 4'd7,
    EXE_SLL          = 4'd8,
    EXE_SRA          = 4'd9,
    EXE_SRL          = 4'd10,
    EXE_MUL          = 4'd11
  } execmd_t;

  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_JUMP = 2'd1,
    COND_BEZ  = 2'd2,
    COND_BNE  = 2'd3
  } brcmd_t;

  typedef struct packed {
    execmd_t exe_cmd;
    brcmd_t  br_cmd;
    logic    branch_en;
    logic    is_imm;
    logic    st_or_bne;
    logic    wb_en;
    logic    mem_r_en;
    logic    mem_w_en;
  } ctrl_t;

endpackage

interface ctrl_decode_pipe_if #(
  parameter int REG_AW      = 4,
  parameter int STALL_CNT_W = 16
) ();
  import ctrl_decode_pkg::*;

  logic                   id_valid_i;
  opcode_t                opCode_i;
  logic [REG_AW-1:0]      src1_i;
  logic [REG_AW-1:0]      src2_i;
  logic [REG_AW-1:0]      dest_i;
  logic                   flush_i;
  logic                   stall_o;
  logic                   mul_busy_o;
  logic                   ex_valid_o;
  logic [REG_AW-1:0]      ex_dest_o;
  execmd_t                EXE_CMD_o;
  brcmd_t                 Branch_command_o;
  logic                   branchEn_o;
  logic                   Is_Imm_o;
  logic                   ST_or_BNE_o;
  logic                   WB_EN_o;
  logic                   MEM_R_EN_o;
  logic                   MEM_W_EN_o;
  logic [STALL_CNT_W-1:0] stall_count_o;

  modport slave (
    input  id_valid_i, opCode_i, src1_i, src2_i, dest_i, flush_i,
    output stall_o, mul_busy_o, ex_valid_o, ex_dest_o, EXE_CMD_o, Branch_command_o,
           branchEn_o, Is_Imm_o, ST_or_BNE_o, WB_EN_o, MEM_R_EN_o, MEM_W_EN_o,
           stall_count_o
  );

  modport master (
    output id_valid_i, opCode_i, src1_i, src2_i, dest_i, flush_i,
    input  stall_o, mul_busy_o, ex_valid_o, ex_dest_o, EXE_CMD_o, Branch_command_o,
           branchEn_o, Is_Imm_o, ST_or_BNE_o, WB_EN_o, MEM_R_EN_o, MEM_W_EN_o,
           stall_count_o
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decoder with ID/EX control register, internal load-use hazard
// detection, multi-cycle multiply stall FSM, branch flush and a stall-cycle counter.
module ctrl_decode_pipe
  import ctrl_decode_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MUL_LATENCY = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrl_decode_pipe_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_LATENCY - 1);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t             dec_p0;
  logic              uses_src2_p0;
  logic              hz_p0;
  ctrl_t             ctrl_p1;
  logic              vld_p1;
  logic [REG_AW-1:0] dest_p1;
  state_t            state_p1, state_nx;
  logic [7:0]        cnt_p1, cnt_nx;
  logic [STALL_CNT_W-1:0] stall_cnt_p1;

  // ---- p0: combinational decode and hazard detection in ID
  always_comb begin
    dec_p0       = '0;
    uses_src2_p0 = 1'b0;
    case (bus.opCode_i)
      OP_ADD:  begin dec_p0.exe_cmd = EXE_ADD; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_SUB:  begin dec_p0.exe_cmd = EXE_SUB; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_AND:  begin dec_p0.exe_cmd = EXE_AND; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_OR:   begin dec_p0.exe_cmd = EXE_OR;  dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_NOR:  begin dec_p0.exe_cmd = EXE_NOR; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_XOR:  begin dec_p0.exe_cmd = EXE_XOR; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_SLA:  begin dec_p0.exe_cmd = EXE_SLA; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_SLL:  begin dec_p0.exe_cmd = EXE_SLL; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_SRA:  begin dec_p0.exe_cmd = EXE_SRA; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_SRL:  begin dec_p0.exe_cmd = EXE_SRL; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_MUL:  begin dec_p0.exe_cmd = EXE_MUL; dec_p0.wb_en = 1'b1; uses_src2_p0 = 1'b1; end
      OP_ADDI: begin dec_p0.exe_cmd = EXE_ADD; dec_p0.wb_en = 1'b1; dec_p0.is_imm = 1'b1; end
      OP_SUBI: begin dec_p0.exe_cmd = EXE_SUB; dec_p0.wb_en = 1'b1; dec_p0.is_imm = 1'b1; end
      OP_LD: begin
        dec_p0.exe_cmd   = EXE_ADD;
        dec_p0.wb_en     = 1'b1;
        dec_p0.is_imm    = 1'b1;
        dec_p0.st_or_bne = 1'b1;
        dec_p0.mem_r_en  = 1'b1;
      end
      OP_ST: begin
        dec_p0.exe_cmd   = EXE_ADD;
        dec_p0.is_imm    = 1'b1;
        dec_p0.st_or_bne = 1'b1;
        dec_p0.mem_w_en  = 1'b1;
        uses_src2_p0     = 1'b1;
      end
      OP_BEZ: begin dec_p0.is_imm = 1'b1; dec_p0.branch_en = 1'b1; dec_p0.br_cmd = COND_BEZ; end
      OP_JMP: begin dec_p0.is_imm = 1'b1; dec_p0.branch_en = 1'b1; dec_p0.br_cmd = COND_JUMP; end
      OP_BNE: begin
        dec_p0.is_imm    = 1'b1;
        dec_p0.branch_en = 1'b1;
        dec_p0.st_or_bne = 1'b1;
        dec_p0.br_cmd    = COND_BNE;
        uses_src2_p0     = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz_p0 = vld_p1 & ctrl_p1.mem_r_en & (dest_p1 != '0) & bus.id_valid_i &
                 ((bus.src1_i == dest_p1) | (uses_src2_p0 & (bus.src2_i == dest_p1)));

  assign bus.stall_o    = ((state_p1 == BUSY) | hz_p0) & ~bus.flush_i;
  assign bus.mul_busy_o = (state_p1 == BUSY);

  always_comb begin
    state_nx = state_p1;
    cnt_nx   = cnt_p1;
    if (bus.flush_i) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (state_p1 == BUSY) begin
      cnt_nx = cnt_p1 - 1'b1;
      if (cnt_p1 == 8'd1) state_nx = IDLE;
    end else if (!hz_p0 && bus.id_valid_i && bus.opCode_i == OP_MUL && MUL_LATENCY > 1) begin
      state_nx = BUSY;
      cnt_nx   = MUL_LOAD;
    end
  end

  // ---- p1: ID/EX control register, FSM state and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1     <= IDLE;
      cnt_p1       <= '0;
      ctrl_p1      <= '0;
      vld_p1       <= 1'b0;
      dest_p1      <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      state_p1 <= state_nx;
      cnt_p1   <= cnt_nx;
      if (bus.stall_o) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (bus.flush_i || (state_p1 != BUSY && hz_p0)) begin
        ctrl_p1 <= '0;
        vld_p1  <= 1'b0;
        dest_p1 <= '0;
      end else if (state_p1 != BUSY) begin
        ctrl_p1 <= bus.id_valid_i ? dec_p0 : '0;
        vld_p1  <= bus.id_valid_i;
        dest_p1 <= bus.dest_i;
      end
    end
  end

  assign bus.ex_valid_o       = vld_p1;
  assign bus.ex_dest_o        = dest_p1;
  assign bus.EXE_CMD_o        = ctrl_p1.exe_cmd;
  assign bus.Branch_command_o = ctrl_p1.br_cmd;
  assign bus.branchEn_o       = ctrl_p1.branch_en;
  assign bus.Is_Imm_o         = ctrl_p1.is_imm;
  assign bus.ST_or_BNE_o      = ctrl_p1.st_or_bne;
  assign bus.WB_EN_o          = ctrl_p1.wb_en;
  assign bus.MEM_R_EN_o       = ctrl_p1.mem_r_en;
  assign bus.MEM_W_EN_o       = ctrl_p1.mem_w_en;
  assign bus.stall_count_o    = stall_cnt_p1;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench: three instances (default, MUL_LATENCY=1, STALL_CNT_W=2) share one stimulus.
module tb_ctrl_decode_pipe;
  import ctrl_decode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  opcode_t    op = OP_NOP;
  logic [3:0] src1 = '0, src2 = '0, dest = '0;
  logic       flush = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe_if #(.REG_AW(4), .STALL_CNT_W(16)) if0 ();
  ctrl_decode_pipe_if #(.REG_AW(4), .STALL_CNT_W(16)) if1 ();
  ctrl_decode_pipe_if #(.REG_AW(4), .STALL_CNT_W(2))  if2 ();

  assign if0.id_valid_i = id_valid; assign if0.opCode_i = op; assign if0.flush_i = flush;
  assign if0.src1_i = src1; assign if0.src2_i = src2; assign if0.dest_i = dest;
  assign if1.id_valid_i = id_valid; assign if1.opCode_i = op; assign if1.flush_i = flush;
  assign if1.src1_i = src1; assign if1.src2_i = src2; assign if1.dest_i = dest;
  assign if2.id_valid_i = id_valid; assign if2.opCode_i = op; assign if2.flush_i = flush;
  assign if2.src1_i = src1; assign if2.src2_i = src2; assign if2.dest_i = dest;

  ctrl_decode_pipe #(.REG_AW(4), .MUL_LATENCY(4), .STALL_CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  ctrl_decode_pipe #(.REG_AW(4), .MUL_LATENCY(1), .STALL_CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ctrl_decode_pipe #(.REG_AW(4), .MUL_LATENCY(4), .STALL_CNT_W(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input opcode_t o, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] d);
    id_valid = v; op = o; src1 = s1; src2 = s2; dest = d;
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_ex_valid", 32'(if0.ex_valid_o), 0);
    chk("rst_exe_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_NO_OPERATION));
    chk("rst_busy", 32'(if0.mul_busy_o), 0);
    chk("rst_count", 32'(if0.stall_count_o), 0);
    tick();
    rst_n = 1'b1;

    // ADDI dest=3
    set_id(1, OP_ADDI, 4'd1, 4'd2, 4'd3);
    chk("addi_stall_pre", 32'(if0.stall_o), 0);
    tick();
    chk("addi_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_ADD));
    chk("addi_wb", 32'(if0.WB_EN_o), 1);
    chk("addi_imm", 32'(if0.Is_Imm_o), 1);
    chk("addi_dest", 32'(if0.ex_dest_o), 3);
    chk("addi_vld", 32'(if0.ex_valid_o), 1);
    chk("addi_stall", 32'(if0.stall_o), 0);

    // LD r5 then ADD using r5 as src1: one bubble
    set_id(1, OP_LD, 4'd1, 4'd0, 4'd5);
    tick();
    chk("ld_memr", 32'(if0.MEM_R_EN_o), 1);
    set_id(1, OP_ADD, 4'd5, 4'd2, 4'd6);
    chk("lu_stall", 32'(if0.stall_o), 1);
    tick();
    chk("lu_bubble_vld", 32'(if0.ex_valid_o), 0);
    chk("lu_bubble_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_NO_OPERATION));
    chk("lu_count", 32'(if0.stall_count_o), 1);
    chk("lu_stall_gone", 32'(if0.stall_o), 0);
    tick();
    chk("lu_add_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_ADD));
    chk("lu_add_dest", 32'(if0.ex_dest_o), 6);
    chk("lu_add_imm", 32'(if0.Is_Imm_o), 0);

    // LD to r0 never stalls
    set_id(1, OP_LD, 4'd1, 4'd0, 4'd0);
    tick();
    set_id(1, OP_ADD, 4'd0, 4'd2, 4'd6);
    chk("ld_r0_stall", 32'(if0.stall_o), 0);
    tick();
    chk("ld_r0_add_vld", 32'(if0.ex_valid_o), 1);

    // ADDI does not read src2
    set_id(1, OP_LD, 4'd1, 4'd0, 4'd5);
    tick();
    set_id(1, OP_ADDI, 4'd1, 4'd5, 4'd7);
    chk("addi_src2_stall", 32'(if0.stall_o), 0);
    tick();

    // ST reads src2
    set_id(1, OP_LD, 4'd1, 4'd0, 4'd5);
    tick();
    set_id(1, OP_ST, 4'd1, 4'd5, 4'd0);
    chk("st_src2_stall", 32'(if0.stall_o), 1);
    tick();
    chk("st_bubble", 32'(if0.ex_valid_o), 0);
    chk("st_count", 32'(if0.stall_count_o), 2);
    tick();
    chk("st_memw", 32'(if0.MEM_W_EN_o), 1);
    chk("st_stbne", 32'(if0.ST_or_BNE_o), 1);
    chk("st_wb", 32'(if0.WB_EN_o), 0);

    // BNE decode
    set_id(1, OP_BNE, 4'd1, 4'd2, 4'd0);
    tick();
    chk("bne_brcmd", 32'(if0.Branch_command_o), 32'(COND_BNE));
    chk("bne_en", 32'(if0.branchEn_o), 1);
    chk("bne_stbne", 32'(if0.ST_or_BNE_o), 1);
    chk("bne_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_NO_OPERATION));

    // Invalid ID slot loads a bubble
    set_id(0, OP_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    chk("inv_vld", 32'(if0.ex_valid_o), 0);
    chk("inv_wb", 32'(if0.WB_EN_o), 0);

    // MUL (latency 4) followed by ADD
    set_id(1, OP_MUL, 4'd1, 4'd2, 4'd7);
    tick();
    chk("mul_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_MUL));
    chk("mul_l1_busy", 32'(if1.mul_busy_o), 0);
    set_id(1, OP_ADD, 4'd1, 4'd2, 4'd8);
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy", 32'(if0.mul_busy_o), 1);
      chk("mul_stall", 32'(if0.stall_o), 1);
      chk("mul_l1_stall", 32'(if1.stall_o), 0);
      chk("mul_held", 32'(if0.ex_dest_o), 7);
      tick();
    end
    chk("mul_4th_busy", 32'(if0.mul_busy_o), 0);
    chk("mul_4th_stall", 32'(if0.stall_o), 0);
    chk("mul_4th_held", 32'(if0.EXE_CMD_o), 32'(EXE_MUL));
    tick();
    chk("mul_add_dest", 32'(if0.ex_dest_o), 8);
    chk("mul_add_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_ADD));
    chk("mul_count", 32'(if0.stall_count_o), 5);
    chk("mul_l1_count", 32'(if1.stall_count_o), 2);
    chk("mul_sat_count", 32'(if2.stall_count_o), 3);

    // Flush during BUSY with cnt=2
    set_id(1, OP_MUL, 4'd1, 4'd2, 4'd9);
    tick();
    set_id(1, OP_ADD, 4'd1, 4'd2, 4'd10);
    tick();
    chk("fl_pre_busy", 32'(if0.mul_busy_o), 1);
    flush = 1'b1;
    #1;
    chk("fl_stall_gated", 32'(if0.stall_o), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_vld", 32'(if0.ex_valid_o), 0);
    chk("fl_busy", 32'(if0.mul_busy_o), 0);
    chk("fl_stall", 32'(if0.stall_o), 0);
    chk("fl_count", 32'(if0.stall_count_o), 6);
    tick();
    chk("fl_add_dest", 32'(if0.ex_dest_o), 10);

    // Five load-use hazards
    for (int i = 0; i < 5; i++) begin
      set_id(1, OP_LD, 4'd1, 4'd0, 4'd5);
      tick();
      set_id(1, OP_ADD, 4'd5, 4'd2, 4'd6);
      tick();
      tick();
    end
    chk("hz5_count", 32'(if0.stall_count_o), 11);
    chk("hz5_l1_count", 32'(if1.stall_count_o), 7);
    chk("hz5_sat", 32'(if2.stall_count_o), 3);

    // Asynchronous reset in the middle of BUSY
    set_id(1, OP_MUL, 4'd1, 4'd2, 4'd11);
    tick();
    tick();
    chk("rb_busy", 32'(if0.mul_busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_vld", 32'(if0.ex_valid_o), 0);
    chk("rb_busy0", 32'(if0.mul_busy_o), 0);
    chk("rb_cmd", 32'(if0.EXE_CMD_o), 32'(EXE_NO_OPERATION));
    chk("rb_dest", 32'(if0.ex_dest_o), 0);
    chk("rb_count", 32'(if0.stall_count_o), 0);
    chk("rb_stall", 32'(if0.stall_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Second-generation control unit: decodes opcode_t into the control bundle, then registers it into the ID/EX control stage.
- Owns load-use hazard detection internally; no external hazard_detected input.
- Adds a parametrised multi-cycle multiply stall FSM, branch flush and a saturating stall-cycle counter.
- Sits between the ID stage and the EXE stage of the 5-stage pipeline.

Parameters:
- REG_AW, 4: register-index width (2^REG_AW architectural registers; R0 is hard zero).
- MUL_LATENCY, 4: EXE cycles an OP_MUL occupies. Legal range 1..255; 1 means no stall.
- STALL_CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous reset, active low.
- id_valid_i  in  1  ID holds a valid instruction.
- opCode_i  in  opcode_t  ID opcode. OP_MUL is added to opcode_t; EXE_MUL is added to execmd_t.
- src1_i  in  REG_AW  first source register index.
- src2_i  in  REG_AW  second source register index.
- dest_i  in  REG_AW  destination register index.
- flush_i  in  1  branch taken in EXE; kill the instruction currently in ID.
- stall_o  out  1  combinational; freezes PC and IF/ID this cycle.
- mul_busy_o  out  1  multiply FSM is in BUSY.
- ex_valid_o  out  1  registered; ID/EX holds a real instruction.
- ex_dest_o  out  REG_AW  registered destination index.
- EXE_CMD_o  out  execmd_t  registered.
- Branch_command_o  out  brcmd_t  registered.
- branchEn_o, Is_Imm_o, ST_or_BNE_o, WB_EN_o, MEM_R_EN_o, MEM_W_EN_o  out  1 each  registered.
- stall_count_o  out  STALL_CNT_W  cycles with stall_o=1, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs 0, EXE_CMD_o=EXE_NO_OPERATION, Branch_command_o=0, FSM=IDLE, counter=0.
- Decode table (combinational, ahead of the register):
  - ALU R-type ops (ADD, SUB, AND, OR, NOR, XOR, SLA, SLL, SRA, SRL): matching EXE_CMD, WB_EN=1.
  - ADDI/SUBI: EXE_ADD/EXE_SUB, WB_EN=1, Is_Imm=1.
  - LD: EXE_ADD, WB_EN, Is_Imm, ST_or_BNE, MEM_R_EN.
  - ST: EXE_ADD, Is_Imm, ST_or_BNE, MEM_W_EN.
  - BEZ/BNE/JMP: EXE_NO_OPERATION, Is_Imm, branchEn, Branch_command=COND_BEZ/COND_BNE/COND_JUMP; BNE also sets ST_or_BNE.
  - MUL: EXE_MUL, WB_EN=1.
  - Unknown opcode: all zero (bubble).
- Uses src2 = R-type ALU ops, MUL, ST, BNE.
- Load-use hazard (hz): ex_valid_o & MEM_R_EN_o & ex_dest_o!=0 & id_valid_i & (src1_i==ex_dest_o | (uses src2 & src2_i==ex_dest_o)).
- FSM states:
  - IDLE: on an OP_MUL loaded into ID/EX with MUL_LATENCY>1, load cnt=MUL_LATENCY-1 and go to BUSY.
  - BUSY: cnt decrements each cycle; when cnt==1, next state is IDLE.
- stall_o = (FSM==BUSY) | hz, gated by !flush_i.
- ID/EX update each clock edge, in priority order:
  1. flush_i: load bubble (all control 0, ex_valid 0); FSM→IDLE, cnt=0.
  2. BUSY: hold ID/EX unchanged (the MUL stays in EXE).
  3. hz: load bubble. Exactly one cycle; next cycle hz is false because EX holds the bubble.
  4. Otherwise: load the decoded bundle; ex_valid_o=id_valid_i; ex_dest_o=dest_i. Control is zeroed when id_valid_i=0.
- Effective MUL residency in EXE is exactly MUL_LATENCY cycles. MUL_LATENCY=1 gives a normal single-cycle op with no stall.
- Back-to-back MUL: the second MUL waits in ID, loads on the first IDLE edge and restarts the count.
- Stall counter: increments on every cycle with stall_o=1, saturates at all-ones, never wraps, cleared only by reset.
- Reset mid-BUSY: immediate return to IDLE with bubble outputs.

Test Plan:
- Reset, then ADDI (dest=3) valid → next cycle EXE_CMD_o=EXE_ADD, WB_EN_o=1, Is_Imm_o=1, ex_dest_o=3, stall_o=0.
- LD dest=5, followed by ADD src1=5 → one cycle stall_o=1, bubble in ID/EX (ex_valid_o=0), ADD enters the cycle after, stall_count_o=1. Repeat with dest=0 → no stall.
- LD dest=5, followed by ADDI src2=5 (src2 unused) → no stall. ST src2=5 → one-cycle stall.
- MUL_LATENCY=4: MUL then ADD → MUL held 4 cycles, stall_o=1 for 3 cycles, mul_busy_o=1 for 3 cycles, ADD enters on the 5th, stall_count_o=3. Repeat with MUL_LATENCY=1 → zero stall.
- During BUSY (cnt=2), assert flush_i → next cycle ex_valid_o=0, mul_busy_o=0, stall_o=0. Assert rst_n=0 mid-BUSY → outputs zero immediately, no clock needed.
- STALL_CNT_W=2: 5 hazard cycles → stall_count_o saturates at 3.
